// File: rtl/ad5302_spi_writer_if.sv
// Command-strobe and DAC serial-pin bundle shared by the AD5302 writer and whatever drives it.
interface ad5302_spi_writer_if;
  logic [31:0] uart_reg;
  logic        uart_ready;
  logic        dac_sync_n;
  logic        dac_sclk;
  logic        dac_din;
  logic        busy;
  logic        done;

  modport master (
    output uart_reg, uart_ready,
    input  dac_sync_n, dac_sclk, dac_din, busy, done
  );

  modport slave (
    input  uart_reg, uart_ready,
    output dac_sync_n, dac_sclk, dac_din, busy, done
  );
endinterface

// File: rtl/ad5302_spi_writer.sv
// Decodes addressed 32-bit UART commands and shifts one 16-bit AD5302 control/data word per
// accepted command out on SYNC_n/SCLK/DIN, MSB first, with all outputs registered.
module ad5302_spi_writer #(
  parameter logic [15:0] ADDRESS    = 16'hDAC0,
  parameter int          CLK_DIV    = 4,
  parameter int          SYNC_SETUP = 2,
  parameter int          SYNC_HIGH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  ad5302_spi_writer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SetupLast = 16'(SYNC_SETUP - 1);
  localparam logic [15:0] GapLast   = 16'(SYNC_HIGH - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [14:0] shreg_q, shreg_d;
  logic        sync_n_q, sync_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sync_n_q <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sync_n_q <= sync_n_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Bit 15 goes straight to DIN at accept, so only the remaining 15 bits are kept for shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sync_n_d = sync_n_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = bus.uart_ready && (bus.uart_reg[31:16] == ADDRESS) && !busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          cnt_d    = '0;
          shreg_d  = bus.uart_reg[14:0];
          sync_n_d = 1'b0;
          din_d    = bus.uart_reg[15];
          busy_d   = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SetupLast) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != DivLast) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (bit_q == 5'd15) begin
              state_d = HOLD;
            end else begin
              din_d   = shreg_q[14];
              shreg_d = {shreg_q[13:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == DivLast) begin
          state_d  = GAP;
          cnt_d    = '0;
          sync_n_d = 1'b1;
          din_d    = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GapLast) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dac_sync_n = sync_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_din    = din_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ad5302_spi_writer.sv
// Bench for ad5302_spi_writer: a default-parameter instance and a fastest-timing instance,
// with an event recorder compared against frame timing computed from the AD5302 frame rules.
module tb_ad5302_spi_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  bit   sel = 1'b0;

  int errors = 0;
  int checks = 0;

  ad5302_spi_writer_if busA ();
  ad5302_spi_writer_if busB ();

  ad5302_spi_writer dutA (.clk(clk), .rst(rst), .bus(busA.slave));

  ad5302_spi_writer #(.ADDRESS(16'hDAC0), .CLK_DIV(1), .SYNC_SETUP(1), .SYNC_HIGH(1)) dutB (
    .clk(clk), .rst(rst), .bus(busB.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder for whichever instance sel points at, sampled on the falling clk edge.
  int   fallCyc[$];
  bit   fallDin[$];
  bit   fallSync[$];
  int   doneCyc[$];
  int   busyFall[$];
  int   stray = 0;
  bit   prevSclk = 1'b1;
  bit   prevBusy = 1'b0;

  always @(negedge clk) begin
    logic sclkNow, syncNow, dinNow, busyNow, doneNow;
    sclkNow = sel ? busB.dac_sclk   : busA.dac_sclk;
    syncNow = sel ? busB.dac_sync_n : busA.dac_sync_n;
    dinNow  = sel ? busB.dac_din    : busA.dac_din;
    busyNow = sel ? busB.busy       : busA.busy;
    doneNow = sel ? busB.done       : busA.done;
    if (prevSclk && !sclkNow) begin
      fallCyc.push_back(cyc);
      fallDin.push_back(dinNow);
      fallSync.push_back(syncNow);
    end
    if ((prevSclk != sclkNow) && syncNow) stray++;
    if (doneNow) doneCyc.push_back(cyc);
    if (prevBusy && !busyNow) busyFall.push_back(cyc);
    prevSclk = sclkNow;
    prevBusy = busyNow;
  end

  int fb, db, bb, sb;

  task automatic markBases();
    fb = fallCyc.size();
    db = doneCyc.size();
    bb = busyFall.size();
    sb = stray;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cyc < target && guard < 100000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Assumes the caller sits just after a rising edge; the strobe is high for exactly this cycle.
  task automatic applyStimulus(input bit which, input logic [31:0] word, output int c0);
    if (which) begin
      busB.uart_reg = word;  busB.uart_ready = 1'b1;
    end else begin
      busA.uart_reg = word;  busA.uart_ready = 1'b1;
    end
    c0 = cyc;
    @(posedge clk);
    #1;
    busA.uart_ready = 1'b0;
    busB.uart_ready = 1'b0;
  endtask

  // Reference frame: fall i at c0+S+1+2Di carrying word bit 15-i, done at c0+S+1+32D, idle G later.
  task automatic checkOutput(input string tag, input int c0, input logic [15:0] w,
                             input int d, input int s, input int g);
    int nFalls;
    nFalls = fallCyc.size() - fb;
    checkEq({tag, " fall count"}, 32'(nFalls), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (fb + i < fallCyc.size()) begin
        checkEq($sformatf("%s fall%0d cycle", tag, i), 32'(fallCyc[fb + i] - c0), 32'(s + 1 + 2 * d * i));
        checkEq($sformatf("%s fall%0d din", tag, i), 32'(fallDin[fb + i]), 32'(w[15 - i]));
        checkEq($sformatf("%s fall%0d sync", tag, i), 32'(fallSync[fb + i]), 32'd0);
      end
    end
    checkEq({tag, " done count"}, 32'(doneCyc.size() - db), 32'd1);
    if (doneCyc.size() > db)
      checkEq({tag, " done cycle"}, 32'(doneCyc[db] - c0), 32'(s + 1 + 32 * d));
    checkEq({tag, " busy fall count"}, 32'(busyFall.size() - bb), 32'd1);
    if (busyFall.size() > bb)
      checkEq({tag, " busy low cycle"}, 32'(busyFall[bb] - c0), 32'(s + 1 + 32 * d + g));
    checkEq({tag, " edges outside frame"}, 32'(stray - sb), 32'd0);
  endtask

  localparam int D = 4, S = 2, G = 4;
  localparam int FrameEnd = S + 1 + 32 * D + G;

  initial begin
    int c0, c1, junk, r1, r2;
    logic [31:0] w32;
    logic [15:0] addr;

    busA.uart_reg = '0;  busA.uart_ready = 1'b0;
    busB.uart_reg = '0;  busB.uart_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    checkEq("reset sync_n", 32'(busA.dac_sync_n), 32'd1);
    checkEq("reset sclk",   32'(busA.dac_sclk),   32'd1);
    checkEq("reset din",    32'(busA.dac_din),    32'd0);
    checkEq("reset busy",   32'(busA.busy),       32'd0);
    checkEq("reset done",   32'(busA.done),       32'd0);

    // Directed frame 0x5A30 at default timing.
    markBases();
    applyStimulus(1'b0, 32'hDAC0_5A30, c0);
    waitUntil(c0 + FrameEnd + 2);
    checkOutput("t1", c0, 16'h5A30, D, S, G);

    // Wrong address must leave the pins idle.
    markBases();
    applyStimulus(1'b0, 32'hDAC1_FFFF, c0);
    waitUntil(c0 + 20);
    checkEq("t2 falls", 32'(fallCyc.size() - fb), 32'd0);
    checkEq("t2 sync_n", 32'(busA.dac_sync_n), 32'd1);
    checkEq("t2 sclk", 32'(busA.dac_sclk), 32'd1);
    checkEq("t2 busy", 32'(busA.busy), 32'd0);

    // A valid strobe mid-frame is dropped.
    markBases();
    applyStimulus(1'b0, 32'hDAC0_C3A5, c0);
    waitUntil(c0 + 50);
    applyStimulus(1'b0, 32'hDAC0_0000, junk);
    waitUntil(c0 + FrameEnd + 10);
    checkOutput("t3", c0, 16'hC3A5, D, S, G);

    // Strobe in the very cycle busy drops is taken.
    markBases();
    applyStimulus(1'b0, 32'hDAC0_9E17, c0);
    waitUntil(c0 + FrameEnd);
    checkEq("t4 busy low at gap end", 32'(busA.busy), 32'd0);
    applyStimulus(1'b0, 32'hDAC0_1BE4, c1);
    checkEq("t4 sync_n low next cycle", 32'(busA.dac_sync_n), 32'd0);
    checkOutput("t4a", c0, 16'h9E17, D, S, G);
    markBases();
    waitUntil(c1 + FrameEnd + 2);
    checkOutput("t4b", c1, 16'h1BE4, D, S, G);

    // Asynchronous reset mid-frame, then a clean frame.
    markBases();
    applyStimulus(1'b0, 32'hDAC0_7F02, c0);
    waitUntil(c0 + 60);
    rst = 1'b1;
    #1;
    checkEq("t5 sync_n", 32'(busA.dac_sync_n), 32'd1);
    checkEq("t5 sclk",   32'(busA.dac_sclk),   32'd1);
    checkEq("t5 din",    32'(busA.dac_din),    32'd0);
    checkEq("t5 busy",   32'(busA.busy),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitUntil(c0 + FrameEnd + 10);
    checkEq("t5 no done", 32'(doneCyc.size() - db), 32'd0);
    checkEq("t5 idle sclk", 32'(busA.dac_sclk), 32'd1);
    markBases();
    applyStimulus(1'b0, 32'hDAC0_B6D9, c0);
    waitUntil(c0 + FrameEnd + 2);
    checkOutput("t5 after", c0, 16'hB6D9, D, S, G);

    // Random words with foreign-address and busy-time strobes sprinkled in.
    for (int k = 0; k < 6; k++) begin
      markBases();
      w32 = {16'hDAC0, 16'($urandom)};
      applyStimulus(1'b0, w32, c0);
      r1 = int'($urandom_range(1, 60));
      r2 = int'($urandom_range(62, 133));
      addr = 16'($urandom);
      if (addr == 16'hDAC0) addr = 16'hDAC1;
      waitUntil(c0 + r1);
      applyStimulus(1'b0, {addr, 16'($urandom)}, junk);
      waitUntil(c0 + r2);
      applyStimulus(1'b0, {16'hDAC0, 16'($urandom)}, junk);
      waitUntil(c0 + FrameEnd + 2);
      checkOutput($sformatf("rnd%0d", k), c0, w32[15:0], D, S, G);
    end

    // Fastest timing instance.
    sel = 1'b1;
    @(posedge clk);
    #1;
    markBases();
    applyStimulus(1'b1, 32'hDAC0_8001, c0);
    waitUntil(c0 + 1 + 1 + 32 + 1 + 2);
    checkOutput("t6", c0, 16'h8001, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
